nes_joypad_bridge: RTL
======================

Name: nes_joypad_bridge

Overview:
Parametrised joypad front-end between N external NES/SNES-style serial pads and the NES core's per-port strobe/clock/data interface.
- Passthrough mode: the core's strobe and clocks are forwarded to the pads, and pad data is synchronised and inverted back to the core.
- Autopoll mode: the block polls all pads itself at a fixed interval and exposes a parallel button bus. It also serves the core's serial reads from an internal 4021-style shift register per port.
- Sits in top, beside the NES core, on the 21 MHz system clock.

Parameters:
NUM_PADS, 2, number of pad channels (1..4)
BITS, 8, bits shifted per pad per poll (8 = NES, 16 = SNES)
CLK_DIV, 126, pad clock half-period in clock cycles; constraint CLK_DIV >= SYNC_STAGES+1
POLL_INTERVAL, 350000, clock cycles spent in IDLE between autopolls (>= 2)
SYNC_STAGES, 2, flops in the pad_data synchroniser (>= 2)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
mode  in  1  0 = passthrough, 1 = autopoll
nes_strobe  in  1  strobe from NES core
nes_clock  in  NUM_PADS  per-port read clock from NES core
nes_data  out  NUM_PADS  per-port serial bit to NES core, active-high = pressed
pad_strobe  out  1  strobe/latch to pads
pad_clock  out  NUM_PADS  clock to pads, idle high
pad_data  in  NUM_PADS  raw pad serial data, active-low, asynchronous
buttons  out  NUM_PADS*BITS  last completed poll; bit [i*BITS+k] = k-th bit of pad i, 1 = pressed
buttons_valid  out  1  one-cycle pulse when buttons updates
busy  out  1  high while the poll FSM is not IDLE

Behaviour:
- Reset values: pad_strobe=0, pad_clock=all 1, nes_data=0, buttons=0, buttons_valid=0, busy=0. FSM=IDLE, interval counter=0, synchronisers=1, shadow registers=0, mode_r=0.
- pad_data passes through a SYNC_STAGES flop chain. Below, "sync[i]" means the synchroniser output.
- mode_r loads from mode only while the FSM is in IDLE. A mode change during a poll takes effect after DONE. In passthrough the FSM is held in IDLE and the interval counter is held at 0.
- Passthrough (mode_r=0):
  - pad_strobe <= nes_strobe and pad_clock <= nes_clock, registered (1-cycle latency).
  - nes_data[i] <= ~sync[i] on any cycle with nes_strobe=1.
  - nes_data[i] <= ~sync[i] on any cycle where nes_clock[i] is 0 and was 1 on the previous cycle (falling edge; previous-value register per port).
  - Otherwise nes_data[i] holds.
- Autopoll FSM (mode_r=1):
  - IDLE: counter counts up. At POLL_INTERVAL-1 the counter clears and the FSM goes to LATCH next cycle.
  - LATCH: pad_strobe=1 for 2*CLK_DIV cycles.
  - SETTLE: pad_strobe=0, pad_clock=1, for CLK_DIV cycles. On its last cycle, bit 0 is captured for every pad: sh[i][0] <= ~sync[i].
  - LOW: pad_clock=0 for CLK_DIV cycles.
  - HIGH: pad_clock=1 for CLK_DIV cycles. On its last cycle, bit k is captured, k = 1..BITS-1.
  - After HIGH, go to LOW while k < BITS-1, else DONE.
  - DONE: 1 cycle. buttons <= sh, buttons_valid=1, then IDLE.
  - Poll length: 2*CLK_DIV + CLK_DIV + (BITS-1)*2*CLK_DIV + 1 cycles.
  - All pads share one phase sequence; pad_clock bits toggle together.
- Autopoll core-side 4021 emulation, per port i:
  - While nes_strobe=1: shadow[i] <= buttons[i*BITS +: BITS].
  - On a falling edge of nes_clock[i]: shadow[i] <= {1'b1, shadow[i][BITS-1:1]}.
  - nes_data[i] = shadow[i][0], registered.
  - Reads past BITS return 1.
  - A buttons update mid-read does not disturb shadow until the next strobe.
- Strobe and clock-edge in the same cycle: strobe load wins.
- Reset asserted mid-poll: immediate return to the reset values above. The next poll starts POLL_INTERVAL cycles after reset release if mode=1.
- busy = (state != IDLE).

Test Plan:
Bench params: NUM_PADS=2, BITS=8, CLK_DIV=4, POLL_INTERVAL=64, SYNC_STAGES=2. The pad model is a 4021 fed from a per-pad active-low byte.
1. Reset, then mode=1, pad0 pressed mask 0x81, pad1 pressed mask 0x3C -> first pad_strobe rise 64 cycles after release; busy for 69 cycles; buttons_valid pulses once; buttons[7:0]=0x81, buttons[15:8]=0x3C.
2. Autopoll, buttons=0x81: core pulses nes_strobe, then 10 nes_clock[0] falling edges -> nes_data[0] sequence 1,0,0,0,0,0,0,1, then 1,1.
3. mode=0, nes_strobe and nes_clock toggled by bench, pad1 byte 0x55 -> pad_strobe/pad_clock mirror the inputs 1 cycle late; nes_data[1] yields 0x55 (LSB first, after inversion of the active-low wire).
4. mode flipped 1->0 mid-poll -> poll completes with valid buttons; passthrough starts only after DONE; no truncated strobe.
5. reset asserted during HIGH phase of bit 3 -> all outputs at reset values in the same cycle; buttons=0; no buttons_valid pulse.
6. nes_strobe=1 in the same cycle as a nes_clock[0] falling edge -> shadow reloads (nes_data[0] = bit 0 of buttons), no shift.

Source files
------------

// File: rtl/nes_joypad_bridge.sv
// nes_joypad_bridge: front-end between serial NES/SNES pads and the NES core's
// per-port strobe/clock/data interface. Passthrough forwards the core's pad
// traffic; autopoll scans all pads periodically into a parallel button bus and
// answers the core's serial reads from a 4021-style shadow register per port.
module nes_joypad_bridge #(
  parameter int NUM_PADS      = 2,
  parameter int BITS          = 8,
  parameter int CLK_DIV       = 126,
  parameter int POLL_INTERVAL = 350000,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     mode,
  input  logic                     nes_strobe,
  input  logic [NUM_PADS-1:0]      nes_clock,
  output logic [NUM_PADS-1:0]      nes_data,
  output logic                     pad_strobe,
  output logic [NUM_PADS-1:0]      pad_clock,
  input  logic [NUM_PADS-1:0]      pad_data,
  output logic [NUM_PADS*BITS-1:0] buttons,
  output logic                     buttons_valid,
  output logic                     busy
);

  localparam int CNT_W   = $clog2(POLL_INTERVAL + 1);
  localparam int PHASE_W = $clog2(2 * CLK_DIV + 1);
  localparam int BIT_W   = $clog2(BITS);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_SETTLE, S_LOW, S_HIGH, S_DONE
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    intv_cnt, intv_cnt_nxt;
  logic [PHASE_W-1:0]  phase_cnt, phase_cnt_nxt, phase_end;
  logic [BIT_W-1:0]    bit_idx, bit_idx_nxt, cap_idx;
  logic                cap_en;
  logic                mode_r;
  logic [NUM_PADS-1:0] sync_p [SYNC_STAGES];
  logic [NUM_PADS-1:0] pad_bit;
  logic                strobe_q;
  logic [NUM_PADS-1:0] pclk_q;
  logic [NUM_PADS-1:0] nclk_prev;
  logic [NUM_PADS-1:0] nclk_fall;
  logic [BITS-1:0]     sh     [NUM_PADS];
  logic [BITS-1:0]     shadow [NUM_PADS];

  assign pad_bit    = sync_p[SYNC_STAGES-1];
  assign nclk_fall  = nclk_prev & ~nes_clock;
  assign busy       = (state != S_IDLE);
  // mode_r only changes in IDLE, so a poll in flight keeps driving the pads.
  assign pad_strobe = mode_r ? (state == S_LATCH) : strobe_q;
  assign pad_clock  = mode_r ? {NUM_PADS{state != S_LOW}} : pclk_q;

  // Synchronise the asynchronous active-low pad data lines.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_p[s] <= '1;
    end else begin
      sync_p[0] <= pad_data;
      for (int s = 1; s < SYNC_STAGES; s++) sync_p[s] <= sync_p[s-1];
    end
  end

  // Poll FSM state, interval/phase/bit counters and the IDLE-gated mode latch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      intv_cnt  <= '0;
      phase_cnt <= '0;
      bit_idx   <= '0;
      mode_r    <= 1'b0;
    end else begin
      state     <= state_nxt;
      intv_cnt  <= intv_cnt_nxt;
      phase_cnt <= phase_cnt_nxt;
      bit_idx   <= bit_idx_nxt;
      if (state == S_IDLE) mode_r <= mode;
    end
  end

  // Next-state logic: phase timing and capture strobes for the shared pad sequence.
  always_comb begin
    state_nxt     = state;
    intv_cnt_nxt  = intv_cnt;
    phase_cnt_nxt = phase_cnt + PHASE_W'(1);
    bit_idx_nxt   = bit_idx;
    cap_en        = 1'b0;
    cap_idx       = bit_idx;
    phase_end     = (state == S_LATCH) ? PHASE_W'(2*CLK_DIV-1) : PHASE_W'(CLK_DIV-1);
    case (state)
      S_IDLE: begin
        phase_cnt_nxt = '0;
        // mode (not mode_r) is used here: mode_r is loaded from it this same
        // cycle, and this keeps the first poll exactly POLL_INTERVAL after reset.
        if (!mode) begin
          intv_cnt_nxt = '0;
        end else if (intv_cnt == CNT_W'(POLL_INTERVAL-1)) begin
          intv_cnt_nxt = '0;
          state_nxt    = S_LATCH;
        end else begin
          intv_cnt_nxt = intv_cnt + CNT_W'(1);
        end
      end
      S_LATCH: begin
        if (phase_cnt == phase_end) begin
          phase_cnt_nxt = '0;
          state_nxt     = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (phase_cnt == phase_end) begin
          phase_cnt_nxt = '0;
          cap_en        = 1'b1;
          cap_idx       = '0;
          bit_idx_nxt   = BIT_W'(1);
          state_nxt     = S_LOW;
        end
      end
      S_LOW: begin
        if (phase_cnt == phase_end) begin
          phase_cnt_nxt = '0;
          state_nxt     = S_HIGH;
        end
      end
      S_HIGH: begin
        if (phase_cnt == phase_end) begin
          phase_cnt_nxt = '0;
          cap_en        = 1'b1;
          if (bit_idx < BIT_W'(BITS-1)) begin
            bit_idx_nxt = bit_idx + BIT_W'(1);
            state_nxt   = S_LOW;
          end else begin
            state_nxt   = S_DONE;
          end
        end
      end
      S_DONE: begin
        phase_cnt_nxt = '0;
        bit_idx_nxt   = '0;
        state_nxt     = S_IDLE;
      end
      default: begin
        phase_cnt_nxt = '0;
        state_nxt     = S_IDLE;
      end
    endcase
  end

  // Collect captured bits and publish them as one coherent button word.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PADS; i++) sh[i] <= '0;
      buttons       <= '0;
      buttons_valid <= 1'b0;
    end else begin
      buttons_valid <= (state == S_DONE);
      if (cap_en) begin
        for (int i = 0; i < NUM_PADS; i++) sh[i][cap_idx] <= ~pad_bit[i];
      end
      if (state == S_DONE) begin
        for (int i = 0; i < NUM_PADS; i++) buttons[i*BITS +: BITS] <= sh[i];
      end
    end
  end

  // Core side: passthrough register stage and per-port 4021 shadow emulation.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      strobe_q  <= 1'b0;
      pclk_q    <= '1;
      nclk_prev <= '1;
      nes_data  <= '0;
      for (int i = 0; i < NUM_PADS; i++) shadow[i] <= '0;
    end else begin
      strobe_q  <= nes_strobe;
      pclk_q    <= nes_clock;
      nclk_prev <= nes_clock;
      for (int i = 0; i < NUM_PADS; i++) begin
        // Strobe reload has priority over a coincident clock falling edge.
        if (nes_strobe)        shadow[i] <= buttons[i*BITS +: BITS];
        else if (nclk_fall[i]) shadow[i] <= {1'b1, shadow[i][BITS-1:1]};
        if (mode_r)                           nes_data[i] <= shadow[i][0];
        else if (nes_strobe || nclk_fall[i])  nes_data[i] <= ~pad_bit[i];
      end
    end
  end

endmodule
